// File: rtl/video2ram_pkg.sv
// Shared definitions for the video capture path:
// FSM state encoding, sync polarity and counter width.
package video2ram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_LINE,
        CAPTURE,
        LINE_END
    } state_t;

    localparam logic SYNC_IDLE   = 1'b1;
    localparam logic SYNC_ACTIVE = 1'b0;
    localparam int   CNT_W       = 12;

    function automatic logic sync_fall(logic prev, logic cur);
        return (prev == SYNC_IDLE) && (cur == SYNC_ACTIVE);
    endfunction

endpackage

// File: rtl/video2ram_if.sv
// Video-in / line-buffer-out signal bundle.
interface video2ram_if #(
    parameter int AW = 14
) ();
    logic [23:0]   pixel_data;
    logic          pixel_valid;
    logic          hsync_n;
    logic          vsync_n;
    logic          is_interlaced;
    logic [AW-1:0] wraddr;
    logic [23:0]   wrdata;
    logic          wren;
    logic          starttrigger;
    logic          field;

    modport master (
        output pixel_data, pixel_valid, hsync_n, vsync_n, is_interlaced,
        input  wraddr, wrdata, wren, starttrigger, field
    );

    modport slave (
        input  pixel_data, pixel_valid, hsync_n, vsync_n, is_interlaced,
        output wraddr, wrdata, wren, starttrigger, field
    );
endinterface

// File: rtl/video2ram_sync_edge_detect.sv
// Single-cycle pulse on the assertion (1->0) of an active-low sync.
module sync_edge_detect
    import video2ram_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic sync_n,
    output logic pulse
);
    logic prev;

    always_ff @(posedge clock) begin
        if (reset) prev <= SYNC_IDLE;
        else       prev <= sync_n;
    end

    assign pulse = sync_fall(prev, sync_n);
endmodule

// File: rtl/video2ram.sv
// Captures a window of incoming video into a line buffer,
// one BUFFER_LINE_LENGTH slot per captured line.
module video2ram
    import video2ram_pkg::*;
#(
    parameter int RAM_WIDTH          = 14,
    parameter int RAM_NUMWORDS       = 16384,
    parameter int BUFFER_LINE_LENGTH = 720,
    parameter int H_START            = 0,
    parameter int H_ACTIVE           = 640,
    parameter int V_START            = 0,
    parameter int V_ACTIVE           = 480,
    parameter int TRIGGER_LINE       = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [23:0]          pixel_data,
    input  logic                 pixel_valid,
    input  logic                 hsync_n,
    input  logic                 vsync_n,
    input  logic                 is_interlaced,
    output logic [RAM_WIDTH-1:0] wraddr,
    output logic [23:0]          wrdata,
    output logic                 wren,
    output logic                 starttrigger,
    output logic                 field
);
    localparam logic [RAM_WIDTH-1:0] LINE_LEN =
        RAM_WIDTH'(BUFFER_LINE_LENGTH);
    localparam logic [RAM_WIDTH-1:0] BASE_LIMIT =
        RAM_WIDTH'(RAM_NUMWORDS - BUFFER_LINE_LENGTH);
    localparam logic [CNT_W-1:0] X_FIRST = CNT_W'(H_START);
    localparam logic [CNT_W-1:0] X_SPAN  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_FIRST = CNT_W'(V_START);
    localparam logic [CNT_W-1:0] V_LINES = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] TRIG    = CNT_W'(TRIGGER_LINE);

    state_t state;
    state_t state_nxt;

    logic                 hs;
    logic                 vs;
    logic [CNT_W-1:0]     x;
    logic [CNT_W-1:0]     vcount;
    logic [CNT_W-1:0]     lines;
    logic [RAM_WIDTH-1:0] line_base;
    logic [CNT_W:0]       x_rel;
    logic [RAM_WIDTH-1:0] offset;
    logic                 in_window;
    logic                 do_write;
    logic                 line_done;
    logic                 at_trigger;
    logic                 trig_q;

    sync_edge_detect u_hsync (
        .clock  (clock),
        .reset  (reset),
        .sync_n (hsync_n),
        .pulse  (hs)
    );

    sync_edge_detect u_vsync (
        .clock  (clock),
        .reset  (reset),
        .sync_n (vsync_n),
        .pulse  (vs)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // vsync restarts the frame from any state and wins over hsync
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: state_nxt = IDLE;
            WAIT_LINE: begin
                if (hs && (vcount + 1'b1) >= V_FIRST)
                    state_nxt = CAPTURE;
            end
            CAPTURE: begin
                if (hs) state_nxt = LINE_END;
            end
            LINE_END: state_nxt = CAPTURE;
        endcase
        if (vs) state_nxt = WAIT_LINE;
    end

    // borrow bit of x_rel flags pixels left of the window
    assign x_rel     = {1'b0, x} - {1'b0, X_FIRST};
    assign in_window = !x_rel[CNT_W] && (x_rel[CNT_W-1:0] < X_SPAN);
    assign offset    = RAM_WIDTH'(x_rel[CNT_W-1:0]);

    assign do_write = (state == CAPTURE) && pixel_valid && in_window
                   && (lines < V_LINES) && !hs && !vs;

    assign line_done  = (state == LINE_END) && (lines < V_LINES);
    assign at_trigger = line_done && ((lines + 1'b1) == TRIG);

    assign starttrigger = trig_q | at_trigger;

    always_ff @(posedge clock) begin
        if (reset) begin
            wren      <= 1'b0;
            wraddr    <= '0;
            wrdata    <= '0;
            x         <= '0;
            vcount    <= '0;
            lines     <= '0;
            line_base <= '0;
            trig_q    <= 1'b0;
            field     <= 1'b0;
        end else begin
            wren <= do_write;
            if (do_write) begin
                wraddr <= line_base + offset;
                wrdata <= pixel_data;
            end

            if (vs || hs)         x <= '0;
            else if (pixel_valid) x <= x + 1'b1;

            if (at_trigger) trig_q <= 1'b1;

            if (vs) begin
                vcount    <= '0;
                lines     <= '0;
                line_base <= '0;
                field     <= is_interlaced ? ~field : 1'b0;
            end else begin
                if (state == WAIT_LINE && hs)
                    vcount <= vcount + 1'b1;
                if (line_done) begin
                    lines     <= lines + 1'b1;
                    line_base <= (line_base < BASE_LIMIT)
                               ? line_base + LINE_LEN : '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_video2ram.sv
// Randomized bench for video2ram against a frame/line level model.
module tb_video2ram;
    localparam int AW  = 5;
    localparam int NW  = 24;
    localparam int BLL = 8;
    localparam int HS  = 2;
    localparam int HA  = 8;
    localparam int VS  = 1;
    localparam int VA  = 4;
    localparam int TL  = 2;

    typedef struct {
        logic [AW-1:0] addr;
        logic [23:0]   data;
        int            stamp;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    video2ram_if #(.AW(AW)) vif ();

    video2ram #(
        .RAM_WIDTH          (AW),
        .RAM_NUMWORDS       (NW),
        .BUFFER_LINE_LENGTH (BLL),
        .H_START            (HS),
        .H_ACTIVE           (HA),
        .V_START            (VS),
        .V_ACTIVE           (VA),
        .TRIGGER_LINE       (TL)
    ) dut (
        .clock         (clk),
        .reset         (rst),
        .pixel_data    (vif.pixel_data),
        .pixel_valid   (vif.pixel_valid),
        .hsync_n       (vif.hsync_n),
        .vsync_n       (vif.vsync_n),
        .is_interlaced (vif.is_interlaced),
        .wraddr        (vif.wraddr),
        .wrdata        (vif.wrdata),
        .wren          (vif.wren),
        .starttrigger  (vif.starttrigger),
        .field         (vif.field)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;
    int n_writes = 0;

    wr_t           exp_q[$];
    logic [AW-1:0] wr_log[$];
    wr_t           mon_e;

    // frame/line level model state
    bit m_frame, m_cap, m_trig, m_field;
    int m_wait, m_line, m_x;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (vif.wren === 1'b1) begin
            n_writes++;
            wr_log.push_back(vif.wraddr);
            chk_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL write_unexpected: got addr %0d data %06h cyc %0d, required no write",
                         vif.wraddr, vif.wrdata, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (vif.wraddr !== mon_e.addr || vif.wrdata !== mon_e.data
                    || cyc != mon_e.stamp)
                    $display("FAIL write: got addr %0d data %06h cyc %0d, required addr %0d data %06h cyc %0d",
                             vif.wraddr, vif.wrdata, cyc,
                             mon_e.addr, mon_e.data, mon_e.stamp);
                else
                    pass_cnt++;
            end
        end
    end

    // slots are handed out round-robin across the buffer
    function automatic logic [AW-1:0] base_of(int line);
        return AW'((line % (NW / BLL)) * BLL);
    endfunction

    task automatic model_reset();
        m_frame = 0; m_cap = 0; m_trig = 0; m_field = 0;
        m_wait = 0; m_line = 0; m_x = 0;
    endtask

    task automatic model_vsync();
        m_frame = 1; m_cap = 0; m_wait = 0; m_line = 0; m_x = 0;
        m_field = vif.is_interlaced ? ~m_field : 1'b0;
    endtask

    task automatic model_hsync();
        m_x = 0;
        if (m_frame) begin
            if (!m_cap) begin
                m_wait++;
                if (m_wait >= VS) m_cap = 1;
            end else begin
                if (m_line < VA) m_line++;
                if (m_line >= TL) m_trig = 1;
            end
        end
    endtask

    task automatic model_pixel(logic [23:0] d);
        wr_t e;
        if (m_cap && m_line < VA && m_x >= HS && m_x < HS + HA) begin
            e.addr  = base_of(m_line) + AW'(m_x - HS);
            e.data  = d;
            e.stamp = cyc + 1;
            exp_q.push_back(e);
        end
        m_x++;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            vif.pixel_valid = 1'b0;
            vif.hsync_n     = 1'b1;
            vif.vsync_n     = 1'b1;
        end
    endtask

    // returns on the negedge right after the sync edge was taken
    task automatic pulse(bit h, bit v);
        @(negedge clk);
        vif.pixel_valid = 1'b0;
        vif.hsync_n     = !h;
        vif.vsync_n     = !v;
        if (v)      model_vsync();
        else if (h) model_hsync();
        @(negedge clk);
        vif.hsync_n = 1'b1;
        vif.vsync_n = 1'b1;
    endtask

    task automatic pixel(logic [23:0] d);
        @(negedge clk);
        vif.pixel_valid = 1'b1;
        vif.pixel_data  = d;
        model_pixel(d);
    endtask

    task automatic line_rand(int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            pixel(24'($urandom));
        end
        idle(1);
    endtask

    task automatic start_frame();
        pulse(0, 1); idle(1);
        pulse(1, 0); idle(1);
    endtask

    task automatic test_reset();
        vif.pixel_data = '0; vif.pixel_valid = 1'b0;
        vif.hsync_n = 1'b1; vif.vsync_n = 1'b1;
        vif.is_interlaced = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (vif.wren !== 1'b0) $display("FAIL reset_wren: got %b, required 0", vif.wren);
        else pass_cnt++;
        chk_cnt++;
        if (vif.wraddr !== '0) $display("FAIL reset_wraddr: got %0d, required 0", vif.wraddr);
        else pass_cnt++;
        chk_cnt++;
        if (vif.wrdata !== '0) $display("FAIL reset_wrdata: got %06h, required 0", vif.wrdata);
        else pass_cnt++;
        chk_cnt++;
        if (vif.starttrigger !== 1'b0)
            $display("FAIL reset_trigger: got %b, required 0", vif.starttrigger);
        else pass_cnt++;
        chk_cnt++;
        if (vif.field !== 1'b0) $display("FAIL reset_field: got %b, required 0", vif.field);
        else pass_cnt++;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_single_line();
        int w0;
        w0 = n_writes;
        start_frame();
        for (int i = 1; i <= 12; i++) pixel(24'(i));
        idle(3);
        chk_cnt++;
        if (n_writes - w0 != 8)
            $display("FAIL single_count: got %0d writes, required 8", n_writes - w0);
        else pass_cnt++;
        chk_cnt++;
        if (exp_q.size() != 0)
            $display("FAIL single_drain: got %0d missing, required 0", exp_q.size());
        else pass_cnt++;
        chk_cnt++;
        if (vif.wren !== 1'b0 || vif.wraddr !== AW'(7) || vif.wrdata !== 24'h00000A)
            $display("FAIL single_hold: got wren %b addr %0d data %06h, required 0 7 00000a",
                     vif.wren, vif.wraddr, vif.wrdata);
        else pass_cnt++;
    endtask

    task automatic test_wrap_trigger();
        int w0, want, n;
        w0 = n_writes;
        want = 0;
        start_frame();
        for (int l = 0; l < 5; l++) begin
            n = (l == 2) ? 5 : $urandom_range(10, 14);
            if (l < VA) want += ((n - HS) > HA) ? HA : ((n > HS) ? n - HS : 0);
            line_rand(n);
            chk_cnt++;
            if (vif.starttrigger !== m_trig)
                $display("FAIL trigger_before line %0d: got %b, required %b",
                         l + 1, vif.starttrigger, m_trig);
            else pass_cnt++;
            pulse(1, 0);
            chk_cnt++;
            if (vif.starttrigger !== m_trig)
                $display("FAIL trigger_line_end line %0d: got %b, required %b",
                         l + 1, vif.starttrigger, m_trig);
            else pass_cnt++;
            idle(1);
        end
        idle(2);
        chk_cnt++;
        if (n_writes - w0 != want || exp_q.size() != 0)
            $display("FAIL wrap_count: got %0d writes (%0d missing), required %0d",
                     n_writes - w0, exp_q.size(), want);
        else pass_cnt++;
        for (int k = 0; k < 2; k++) begin
            pulse(0, 1); idle(2);
            chk_cnt++;
            if (vif.starttrigger !== 1'b1)
                $display("FAIL trigger_sticky %0d: got %b, required 1", k, vif.starttrigger);
            else pass_cnt++;
        end
    endtask

    task automatic test_simultaneous();
        int w0;
        start_frame();
        for (int i = 1; i <= 6; i++) pixel(24'h000100 + 24'(i));
        idle(1);
        pulse(1, 1); idle(1);
        chk_cnt++;
        if (exp_q.size() != 0)
            $display("FAIL simul_drain: got %0d missing, required 0", exp_q.size());
        else pass_cnt++;
        w0 = n_writes;
        pulse(1, 0); idle(1);
        line_rand(12);
        idle(2);
        chk_cnt++;
        if (n_writes - w0 != 8 || wr_log[w0] !== AW'(0))
            $display("FAIL simul_first_addr: got %0d writes first addr %0d, required 8 and 0",
                     n_writes - w0, (n_writes > w0) ? wr_log[w0] : AW'(31));
        else pass_cnt++;
    endtask

    task automatic test_interlace();
        vif.is_interlaced = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pulse(0, 1);
            chk_cnt++;
            if (vif.field !== m_field)
                $display("FAIL field_interlaced %0d: got %b, required %b", k, vif.field, m_field);
            else pass_cnt++;
            idle(1);
        end
        vif.is_interlaced = 1'b0;
        for (int k = 0; k < 2; k++) begin
            pulse(0, 1);
            chk_cnt++;
            if (vif.field !== m_field)
                $display("FAIL field_progressive %0d: got %b, required %b", k, vif.field, m_field);
            else pass_cnt++;
            idle(1);
        end
    endtask

    task automatic test_reset_midline();
        int w0;
        vif.is_interlaced = 1'b1;
        start_frame();
        vif.is_interlaced = 1'b0;
        for (int i = 1; i <= 4; i++) pixel(24'h000200 + 24'(i));
        @(negedge clk);
        vif.pixel_valid = 1'b1;
        vif.pixel_data  = 24'h000205;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        vif.pixel_valid = 1'b0;
        chk_cnt++;
        if (vif.wren !== 1'b0) $display("FAIL midreset_wren: got %b, required 0", vif.wren);
        else pass_cnt++;
        chk_cnt++;
        if (vif.starttrigger !== 1'b0)
            $display("FAIL midreset_trigger: got %b, required 0", vif.starttrigger);
        else pass_cnt++;
        chk_cnt++;
        if (vif.field !== 1'b0) $display("FAIL midreset_field: got %b, required 0", vif.field);
        else pass_cnt++;
        w0 = n_writes;
        pulse(1, 0); idle(1);
        line_rand(12);
        idle(2);
        chk_cnt++;
        if (n_writes - w0 != 0)
            $display("FAIL midreset_blocked: got %0d writes, required 0", n_writes - w0);
        else pass_cnt++;
        w0 = n_writes;
        start_frame();
        line_rand(12);
        idle(2);
        chk_cnt++;
        if (n_writes - w0 != 8 || exp_q.size() != 0)
            $display("FAIL midreset_resume: got %0d writes (%0d missing), required 8",
                     n_writes - w0, exp_q.size());
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_line();
        test_wrap_trigger();
        test_simultaneous();
        test_interlace();
        test_reset_midline();
        idle(2);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
